// File: rtl/dram_arbiter24.sv
// Two-port round-robin arbiter in front of the single-ported data RAM.
// Port 0 is the CPU, port 1 the host/DMA loader, which can hold a burst lock.
module dram_arbiter24 #(
   parameter int DATA_AW = 14,
   parameter int DW      = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               p0_req,
   input  logic               p0_we,
   input  logic [DATA_AW-1:0] p0_addr,
   input  logic [DW-1:0]      p0_wdata,
   input  logic               p1_req,
   input  logic               p1_we,
   input  logic [DATA_AW-1:0] p1_addr,
   input  logic [DW-1:0]      p1_wdata,
   input  logic               p1_lock,
   output logic               p0_gnt,
   output logic               p1_gnt,
   output logic               p0_rvalid,
   output logic               p1_rvalid,
   output logic [DW-1:0]      p0_rdata,
   output logic [DW-1:0]      p1_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [DATA_AW-1:0] mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata,
   output logic [15:0]        stall_cnt0,
   output logic [15:0]        stall_cnt1
);

   logic prio;
   logic locked;
   logic rv0, rv1;
   logic gnt0, gnt1;

   // Port 1 wins when uncontested, while locked, or when it holds priority.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (p1_req && (!p0_req || locked || prio)) gnt1 = 1'b1;
         else if (p0_req)                           gnt0 = 1'b1;
      end
   end

   assign p0_gnt = gnt0;
   assign p1_gnt = gnt1;

   // Idle cycles leave the port-0 fields on the bus; only mem_en qualifies them.
   assign mem_en    = gnt0 | gnt1;
   assign mem_we    = gnt1 ? p1_we    : (gnt0 & p0_we);
   assign mem_addr  = gnt1 ? p1_addr  : p0_addr;
   assign mem_wdata = gnt1 ? p1_wdata : p0_wdata;

   assign p0_rvalid = rv0;
   assign p1_rvalid = rv1;
   assign p0_rdata  = mem_rdata;
   assign p1_rdata  = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         prio       <= 1'b0;
         locked     <= 1'b0;
         rv0        <= 1'b0;
         rv1        <= 1'b0;
         stall_cnt0 <= '0;
         stall_cnt1 <= '0;
      end else begin
         if (gnt0)      prio <= 1'b1;
         else if (gnt1) prio <= 1'b0;

         if (gnt1)                 locked <= p1_lock;
         else if (gnt0 || !p1_req) locked <= 1'b0;

         rv0 <= gnt0 & ~p0_we;
         rv1 <= gnt1 & ~p1_we;

         if (p0_req && !gnt0 && stall_cnt0 != 16'hFFFF) stall_cnt0 <= stall_cnt0 + 16'd1;
         if (p1_req && !gnt1 && stall_cnt1 != 16'hFFFF) stall_cnt1 <= stall_cnt1 + 16'd1;
      end
   end

endmodule

// File: doc/dram_arbiter24.md
# dram_arbiter24

Two-port arbiter sharing the single-ported 24-bit data RAM between the multicycle CPU (port 0) and the host/DMA loader that preloads the X/W/b tables (port 1). It accepts at most one access per cycle, grants by round-robin with an optional host burst lock, and routes the 1-cycle synchronous read data back to the winning port. Per-port saturating stall counters expose contention for debug.

## Interface
- DATA_AW, 14, data RAM word-address width
- DW, 24, data word width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- p0_req, p1_req  in  1  access request, held until granted
- p0_we, p1_we  in  1  1 = write, 0 = read; stable while req is high
- p0_addr, p1_addr  in  DATA_AW  word address; stable while req is high
- p0_wdata, p1_wdata  in  DW  write data; stable while req is high
- p1_lock  in  1  host burst lock, sampled only in cycles where port 1 is granted
- p0_gnt, p1_gnt  out  1  access accepted this cycle (combinational)
- p0_rvalid, p1_rvalid  out  1  read data valid; 1 cycle after a read grant
- p0_rdata, p1_rdata  out  DW  read data, meaningful only with rvalid
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  DATA_AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_en with mem_we=0
- stall_cnt0, stall_cnt1  out  16  cycles each port waited with req high and gnt low

## Operation
- State: prio (1 bit, port holding priority), locked (1 bit), rv0/rv1 (read-return pipeline), stall counters.
- Grant, evaluated each cycle when rst=0:
  - only one req high: grant that port.
  - both high: grant port 1 if locked; otherwise grant port prio.
  - none: no grant, mem_en=0, mem_we=0.
- Exactly one of p0_gnt/p1_gnt may be high in a cycle; never both.
- Command mux: mem_en=1 and mem_we/mem_addr/mem_wdata driven from the granted port in the grant cycle. With no grant, mem_addr/mem_wdata hold the port-0 fields (don't-care), mem_we=0.
- prio update on any grant: prio <= other port (granted 0 -> prio=1, granted 1 -> prio=0). No grant: prio unchanged.
- locked update: on a port-1 grant, locked <= p1_lock; on a port-0 grant, or a cycle with p1_req=0, locked <= 0. A locked host therefore gets back-to-back grants until it drops p1_lock or p1_req.
- Read return: rvK <= gnt_K & ~pK_we; pK_rvalid = rvK; pK_rdata = mem_rdata (both ports see the bus; only rvalid qualifies).
- Writes produce no response; gnt completes the write.
- Stall counters: stall_cntK += 1 in cycles with pK_req=1 and pK_gnt=0; saturate at 16'hFFFF; cleared only by rst.
- Requesters must not derive req combinationally from gnt.

## Timing
- Reset (rst=1 at a rising edge): prio=0, locked=0, rv0=rv1=0, stall_cnt0=stall_cnt1=0. While rst is high, p0_gnt=p1_gnt=0, mem_en=0, mem_we=0, and stall counters do not count.
- After reset: p0_gnt=p1_gnt=0, p0_rvalid=p1_rvalid=0, mem_en=mem_we=0, stall_cnt*=0.
- Grant latency: 0 cycles from an uncontested req (same cycle). A contested loser waits at least 1 cycle; unlocked worst case is exactly 1 cycle.
- Read latency: rvalid at grant cycle +1. Back-to-back reads from one port give rvalid on consecutive cycles.
- Reset mid-read: a read granted in cycle t with rst high at the t+1 edge yields no rvalid.
- Simultaneous req with lock: locked=1 and both req -> port 1 wins; port 0 stall_cnt0 increments every such cycle.
- Lock never blocks port 0 when p1_req=0.

## Test plan
- Reset: hold rst 3 cycles with both req high -> gnt=0, mem_en=0, stall_cnt0=stall_cnt1=0 throughout; first cycle after reset -> p0_gnt=1 (prio=0).
- Single port: p0 write addr 0x0010 data 0x123456, then p0 read 0x0010 -> p0_gnt each cycle, p0_rvalid=1 with p0_rdata=0x123456 one cycle after the read grant, p1_rvalid=0.
- Contention: both ports issue reads every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1; stall_cnt0=3, stall_cnt1=3.
- Burst lock: p1 holds req with p1_lock=1 for 4 writes while p0 requests -> 1 grant to p0 (prio=0 before lock), then 4 consecutive p1 grants; p0 granted in the cycle after p1_lock drops.
- Saturation: p1 locked, p0 requesting for 70000 cycles -> stall_cnt0 stops at 0xFFFF.
- Reset mid-read: p1 read granted, rst asserted next edge -> p1_rvalid stays 0; all counters return to 0.
